// File: rtl/if_fetch_pkg.sv
// Shared CPU definitions: fetch packet layout,
// fetch FSM encoding and the bubble instruction.
package if_fetch_pkg;

    localparam int PKT_PC_LSB    = 0;
    localparam int PKT_INSTR_LSB = 32;
    localparam int PKT_PCN_LSB   = 64;
    localparam int PKT_W         = 96;

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Packet = {pc+4, instr, pc}; the add wraps modulo 2^32.
    function automatic logic [PKT_W-1:0] pkt_pack(
        input logic [31:0] pc,
        input logic [31:0] instr
    );
        return {pc + 32'd4, instr, pc};
    endfunction

endpackage

// File: rtl/if_pc_reg.sv
// Program counter register with its next-PC mux:
// reset / branch redirect / sequential +4 / hold.
module if_pc_reg
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch,
    input  logic [31:0] target,
    input  logic        advance,
    output logic [31:0] pc
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    // Redirect beats sequential advance; otherwise hold.
    always_comb begin
        pc_d = pc_q;
        if (branch) begin
            pc_d = target;
        end else if (advance) begin
            pc_d = pc_q + 32'd4;
        end
    end

    // PC state, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, talks to
// instruction memory and builds the IF/ID packet.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          TIMEOUT   = 15,
    parameter logic [31:0] NOP_INSTR = if_fetch_pkg::NOP_INSTR
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Stall,
    input  logic             Branch,
    input  logic [31:0]      BranchTarget,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    input  logic             imem_ready,
    output logic [PKT_W-1:0] dataOut,
    output logic             valid,
    output logic             E,
    output logic [31:0]      pc,
    output logic             fetch_err
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

    logic [1:0]        state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [PKT_W-1:0]  data_q, data_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;

    logic              req;
    logic              advance;
    logic              br_take;
    logic              accept;
    logic [31:0]       pc_cur;

    if_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk     (Clk),
        .rst     (Rst),
        .branch  (br_take),
        .target  (BranchTarget),
        .advance (advance),
        .pc      (pc_cur)
    );

    // A word is taken only if the slot is free or being drained.
    assign accept = imem_ready & (~valid_q | ~Stall) & ~Branch;

    // FSM, packet and timeout next-state logic.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        data_d     = data_q;
        valid_d    = valid_q;
        err_d      = err_q;
        req        = 1'b0;
        advance    = 1'b0;
        br_take    = 1'b0;
        unique case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
                if (Branch) begin
                    br_take    = 1'b1;
                    valid_d    = 1'b0;
                    wait_cnt_d = '0;
                    data_d[PKT_INSTR_LSB +: 32] = NOP_INSTR;
                end
            end
            ST_FETCH: begin
                req = 1'b1;
                if (Branch) begin
                    br_take    = 1'b1;
                    valid_d    = 1'b0;
                    wait_cnt_d = '0;
                    data_d[PKT_INSTR_LSB +: 32] = NOP_INSTR;
                end else if (accept) begin
                    data_d     = pkt_pack(pc_cur, imem_rdata);
                    valid_d    = 1'b1;
                    advance    = 1'b1;
                    wait_cnt_d = '0;
                end else begin
                    if (valid_q && !Stall) begin
                        valid_d = 1'b0;
                    end
                    if (imem_ready) begin
                        wait_cnt_d = '0;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                        if (wait_cnt_d == WAIT_MAX) begin
                            err_d   = 1'b1;
                            valid_d = 1'b0;
                            state_d = ST_HALT;
                        end
                    end
                end
            end
            ST_HALT: begin
                valid_d = 1'b0;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // Stage state; reset abandons any in-flight request.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= ST_BOOT;
            wait_cnt_q <= '0;
            data_q     <= pkt_pack(RESET_PC, NOP_INSTR);
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    assign imem_req  = req;
    assign imem_addr = pc_cur;
    assign pc        = pc_cur;
    assign dataOut   = data_q;
    assign valid     = valid_q;
    assign fetch_err = err_q;
    assign E         = valid_q & ~Stall & ~Branch;

endmodule

// File: tb/tb_if_fetch.sv
// Directed self-checking bench for if_fetch,
// including a second instance with a wrapping RESET_PC.
module tb_if_fetch;

    logic        Clk;
    logic        Rst;
    logic        Stall;
    logic        Branch;
    logic [31:0] BranchTarget;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [95:0] dataOut;
    logic        valid;
    logic        E;
    logic [31:0] pc;
    logic        fetch_err;

    logic        Rst2;
    logic        imem_req2;
    logic [31:0] imem_addr2;
    logic [31:0] imem_rdata2;
    logic        imem_ready2;
    logic [95:0] dataOut2;
    logic        valid2;
    logic        E2;
    logic [31:0] pc2;
    logic        fetch_err2;

    int checks = 0;
    int errors = 0;

    assign imem_rdata  = imem_addr ^ 32'hA5A5_0000;
    assign imem_rdata2 = imem_addr2 ^ 32'hA5A5_0000;

    if_fetch #(
        .RESET_PC  (32'h0000_0000),
        .TIMEOUT   (15),
        .NOP_INSTR (32'h0000_0000)
    ) u_dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .Stall        (Stall),
        .Branch       (Branch),
        .BranchTarget (BranchTarget),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .imem_ready   (imem_ready),
        .dataOut      (dataOut),
        .valid        (valid),
        .E            (E),
        .pc           (pc),
        .fetch_err    (fetch_err)
    );

    if_fetch #(
        .RESET_PC  (32'hFFFF_FFFC),
        .TIMEOUT   (15),
        .NOP_INSTR (32'h0000_0000)
    ) u_dut_w (
        .Clk          (Clk),
        .Rst          (Rst2),
        .Stall        (Stall),
        .Branch       (Branch),
        .BranchTarget (BranchTarget),
        .imem_req     (imem_req2),
        .imem_addr    (imem_addr2),
        .imem_rdata   (imem_rdata2),
        .imem_ready   (imem_ready2),
        .dataOut      (dataOut2),
        .valid        (valid2),
        .E            (E2),
        .pc           (pc2),
        .fetch_err    (fetch_err2)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [95:0] obs,
                       input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        Rst          = 1'b1;
        Rst2         = 1'b1;
        Stall        = 1'b0;
        Branch       = 1'b0;
        BranchTarget = 32'h0;
        imem_ready   = 1'b1;
        imem_ready2  = 1'b1;
        tick();
        tick();

        // reset state
        chk("rst_valid", 96'(valid), 96'(1'b0));
        chk("rst_pc", 96'(pc), 96'(32'h0));
        chk("rst_data", dataOut, {32'h4, 32'h0, 32'h0});
        chk("rst_req", 96'(imem_req), 96'(1'b0));
        chk("rst_err", 96'(fetch_err), 96'(1'b0));
        chk("rst_E", 96'(E), 96'(1'b0));
        chk("rst_w_data", dataOut2,
            {32'h0, 32'h0, 32'hFFFF_FFFC});

        // release: BOOT cycle, then first request
        Rst = 1'b0;
        #1;
        chk("boot_req", 96'(imem_req), 96'(1'b0));
        chk("boot_E", 96'(E), 96'(1'b0));
        tick();
        chk("f1_req", 96'(imem_req), 96'(1'b1));
        chk("f1_addr", 96'(imem_addr), 96'(32'h0));
        chk("f1_valid", 96'(valid), 96'(1'b0));
        tick();
        chk("p0_valid", 96'(valid), 96'(1'b1));
        chk("p0_data", dataOut, {32'h4, 32'hA5A5_0000, 32'h0});
        chk("p0_E", 96'(E), 96'(1'b1));
        chk("p0_pc", 96'(pc), 96'(32'h4));
        tick();
        chk("p4_data", dataOut, {32'h8, 32'hA5A5_0004, 32'h4});
        chk("p4_pc", 96'(pc), 96'(32'h8));

        // stall three cycles with PC 8 pending
        Stall = 1'b1;
        #1;
        chk("st0_E", 96'(E), 96'(1'b0));
        tick();
        chk("st1_data", dataOut, {32'h8, 32'hA5A5_0004, 32'h4});
        chk("st1_valid", 96'(valid), 96'(1'b1));
        chk("st1_E", 96'(E), 96'(1'b0));
        tick();
        chk("st2_data", dataOut, {32'h8, 32'hA5A5_0004, 32'h4});
        chk("st2_pc", 96'(pc), 96'(32'h8));
        tick();
        Stall = 1'b0;
        #1;
        chk("st_rel_E", 96'(E), 96'(1'b1));
        chk("st_rel_data", dataOut, {32'h8, 32'hA5A5_0004, 32'h4});
        chk("st_rel_pc", 96'(pc), 96'(32'h8));
        tick();
        chk("p8_data", dataOut, {32'hC, 32'hA5A5_0008, 32'h8});
        chk("p8_valid", 96'(valid), 96'(1'b1));

        // branch together with ready
        Branch       = 1'b1;
        BranchTarget = 32'h100;
        #1;
        chk("br_E", 96'(E), 96'(1'b0));
        tick();
        Branch = 1'b0;
        #1;
        chk("br_valid", 96'(valid), 96'(1'b0));
        chk("br_pc", 96'(pc), 96'(32'h100));
        chk("br_addr", 96'(imem_addr), 96'(32'h100));
        chk("br_nop", 96'(dataOut[63:32]), 96'(32'h0));
        chk("br_E2", 96'(E), 96'(1'b0));
        tick();
        chk("p100_data", dataOut,
            {32'h104, 32'hA5A5_0100, 32'h100});

        // memory timeout
        imem_ready = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        chk("to14_req", 96'(imem_req), 96'(1'b1));
        chk("to14_err", 96'(fetch_err), 96'(1'b0));
        chk("to14_valid", 96'(valid), 96'(1'b0));
        tick();
        chk("to_err", 96'(fetch_err), 96'(1'b1));
        chk("to_req", 96'(imem_req), 96'(1'b0));
        chk("to_pc", 96'(pc), 96'(32'h104));
        Branch       = 1'b1;
        BranchTarget = 32'h200;
        tick();
        Branch = 1'b0;
        #1;
        chk("halt_br_pc", 96'(pc), 96'(32'h104));
        chk("halt_br_req", 96'(imem_req), 96'(1'b0));
        chk("halt_br_err", 96'(fetch_err), 96'(1'b1));
        chk("halt_E", 96'(E), 96'(1'b0));

        // reset recovers from HALT
        Rst        = 1'b1;
        imem_ready = 1'b1;
        tick();
        chk("rec_err", 96'(fetch_err), 96'(1'b0));
        chk("rec_pc", 96'(pc), 96'(32'h0));
        Rst = 1'b0;
        tick();
        chk("rec_req", 96'(imem_req), 96'(1'b1));
        chk("rec_addr", 96'(imem_addr), 96'(32'h0));

        // reset in the middle of a wait
        imem_ready = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("mid_wait", 96'(u_dut.wait_cnt_q), 96'(4'd7));
        chk("mid_req", 96'(imem_req), 96'(1'b1));
        Rst        = 1'b1;
        imem_ready = 1'b1;
        tick();
        Rst = 1'b0;
        #1;
        chk("mid_valid", 96'(valid), 96'(1'b0));
        chk("mid_pc", 96'(pc), 96'(32'h0));
        chk("mid_data", dataOut, {32'h4, 32'h0, 32'h0});
        chk("mid_boot_req", 96'(imem_req), 96'(1'b0));
        chk("mid_wcnt", 96'(u_dut.wait_cnt_q), 96'(4'd0));
        tick();
        chk("mid_f_req", 96'(imem_req), 96'(1'b1));
        chk("mid_f_addr", 96'(imem_addr), 96'(32'h0));
        tick();
        chk("mid_p0", dataOut, {32'h4, 32'hA5A5_0000, 32'h0});

        // PC wrap instance
        Rst2 = 1'b0;
        #1;
        chk("w_boot_req", 96'(imem_req2), 96'(1'b0));
        tick();
        chk("w_addr", 96'(imem_addr2), 96'(32'hFFFF_FFFC));
        tick();
        chk("w_data", dataOut2,
            {32'h0, 32'h5A5A_FFFC, 32'hFFFF_FFFC});
        chk("w_next_addr", 96'(imem_addr2), 96'(32'h0));
        chk("w_valid", 96'(valid2), 96'(1'b1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage of the pipelined CPU, directly upstream of the IF/ID pipeline register.
- Owns the program counter and issues requests to instruction memory over a request/ready handshake.
- Handles stalls from the hazard unit and branch redirects.
- Emits the 96-bit fetch packet plus the enable that drives IF/ID.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT, 15, maximum cycles to wait for imem_ready before flagging a fetch error.
- NOP_INSTR, 32'h0000_0000, instruction field placed in a bubble packet.

Ports:
- Clk  in  1  single clock; all state updates on its rising edge.
- Rst  in  1  synchronous, active-high reset.
- Stall  in  1  hazard unit: hold the current packet and PC.
- Branch  in  1  redirect request from EX.
- BranchTarget  in  32  redirect PC, valid when Branch=1.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; equals pc while imem_req=1.
- imem_rdata  in  32  instruction word, valid when imem_ready=1.
- imem_ready  in  1  memory completes the current request this cycle.
- dataOut  out  96  packet: [95:64]=PC+4, [63:32]=instruction, [31:0]=PC.
- valid  out  1  dataOut holds a real instruction.
- E  out  1  IF/ID enable = valid & ~Stall & ~Branch (combinational).
- pc  out  32  current fetch PC.
- fetch_err  out  1  sticky; set on memory timeout.

Behaviour:
- Registers:
  - pc, 32 bits.
  - state ∈ {BOOT, FETCH, HALT}.
  - wait_cnt, width clog2(TIMEOUT+1).
  - dataOut, valid, fetch_err.
- Reset (Rst=1 at an edge, dominates everything):
  - pc=RESET_PC, state=BOOT, dataOut={RESET_PC+4, NOP_INSTR, RESET_PC}, valid=0, wait_cnt=0, fetch_err=0.
  - Reset asserted mid-request abandons the request. Any imem_ready in that cycle is ignored.
- BOOT: imem_req=0 for exactly one cycle, then state=FETCH. The first request goes out on cycle 2 after reset release.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - accept = imem_ready & (~valid | ~Stall) & ~Branch.
  - On accept:
    - dataOut <= {pc+4, imem_rdata, pc}; valid <= 1; pc <= pc+4; wait_cnt <= 0.
    - Packet is visible the cycle after ready, so latency is 1.
    - Back-to-back ready gives one instruction per cycle.
  - imem_ready=1 but valid=1 & Stall=1: the word is dropped and pc is unchanged. imem_req stays high and the fetch re-issues after the stall.
  - Consumed packet with no new accept (valid & ~Stall & ~accept): valid <= 0; dataOut holds its value.
  - Stall with valid=1: dataOut and valid are held unchanged.
  - wait_cnt:
    - Increments each FETCH cycle without imem_ready.
    - On reaching TIMEOUT: fetch_err <= 1, state <= HALT.
    - Resets to 0 on any ready and on Branch.
- Branch=1 in BOOT or FETCH (priority over Stall and accept):
  - pc <= BranchTarget, valid <= 0, dataOut instr field <= NOP_INSTR, wait_cnt <= 0.
  - Any same-cycle imem_rdata is discarded.
  - Next FETCH request addresses BranchTarget.
- HALT:
  - imem_req=0, valid=0, pc frozen.
  - Only Rst exits HALT; Branch is ignored.
- pc arithmetic: 32-bit, wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0). BranchTarget is used unaligned as given; no check.
- E is low whenever valid=0. It is never asserted in the BOOT or HALT cycle.

Decomposition:
- Shared cpu package holds:
  - Packet field offsets: PKT_PC_LSB=0, PKT_INSTR_LSB=32, PKT_PCN_LSB=64, PKT_W=96.
  - State encoding.
  - NOP_INSTR.
- IF/ID and ID decode use the same field offsets.
- One natural sub-module: if_pc_reg. It holds the PC register and next-PC mux (reset / branch / +4 / hold) and exports pc. The FSM and packet register stay in if_fetch.

Test Plan:
- Reset, imem_ready=1 every cycle, instr = addr ^ 32'hA5A5_0000 → first valid packet {4, A5A5_0000, 0} appears 3 cycles after Rst release; then one packet per cycle with PC 0, 4, 8.
- Stall=1 for 3 cycles while valid, with PC=8 pending → dataOut frozen, E=0, pc stays 8. After release, E=1 and the next packet has PC 8.
- Branch=1 with BranchTarget=32'h100 in the same cycle as imem_ready → valid=0 next cycle, ready word dropped, next request addr 32'h100, packet PC 32'h100.
- imem_ready held low for TIMEOUT=15 cycles → fetch_err=1 and imem_req=0 thereafter. Branch does not recover; Rst clears fetch_err and restarts at RESET_PC.
- Rst asserted mid-wait with wait_cnt=7 → all outputs return to reset values next cycle and a fresh request goes to RESET_PC after the BOOT cycle.
- RESET_PC=32'hFFFF_FFFC → first packet is {0, instr, FFFF_FFFC}, and the next request addresses 0.
